// File: rtl/pu_riscv_apb4_slave_mux.sv
// APB4 decoder/multiplexer: one master to SLAVES base/mask-decoded slaves, with
// unmapped-address errors, a PREADY watchdog and sticky error capture.
// Optional privileged-slave check is enabled by defining APB_PROT_CHECK_EN.
module pu_riscv_apb4_slave_mux #(
  parameter int unsigned                    PADDR_SIZE     = 16,
  parameter int unsigned                    PDATA_SIZE     = 32,
  parameter int unsigned                    SLAVES         = 4,
  parameter logic [SLAVES*PADDR_SIZE-1:0]   SLV_ADDR       = {16'h8000, 16'h0800, 16'h0400, 16'h0000},
  parameter logic [SLAVES*PADDR_SIZE-1:0]   SLV_MASK       = {16'h8000, 16'hFC00, 16'hFC00, 16'hFC00},
  parameter int unsigned                    TIMEOUT_CYCLES = 256,
  parameter logic [SLAVES-1:0]              SLV_PRIV       = '0
) (
  input  logic                         PCLK,
  input  logic                         PRESET,

  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [2:0]                   PPROT,
  input  logic [PADDR_SIZE-1:0]        PADDR,
  input  logic [PDATA_SIZE/8-1:0]      PSTRB,
  input  logic [PDATA_SIZE-1:0]        PWDATA,
  output logic [PDATA_SIZE-1:0]        PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,

  output logic [SLAVES-1:0]            SLV_PSEL,
  output logic [SLAVES-1:0]            SLV_PENABLE,
  output logic [PADDR_SIZE-1:0]        SLV_PADDR,
  output logic                         SLV_PWRITE,
  output logic [2:0]                   SLV_PPROT,
  output logic [PDATA_SIZE/8-1:0]      SLV_PSTRB,
  output logic [PDATA_SIZE-1:0]        SLV_PWDATA,
  input  logic [SLAVES*PDATA_SIZE-1:0] SLV_PRDATA,
  input  logic [SLAVES-1:0]            SLV_PREADY,
  input  logic [SLAVES-1:0]            SLV_PSLVERR,

  output logic                         err_valid_o,
  output logic [1:0]                   err_cause_o,
  output logic [PADDR_SIZE-1:0]        err_addr_o,
  input  logic                         err_clr_i
);

  localparam int unsigned SEL_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

`ifdef APB_PROT_CHECK_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  localparam logic [1:0] CAUSE_UNMAPPED = 2'b01;
  localparam logic [1:0] CAUSE_PROT     = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ERRACC = 2'd2,
    ST_ABORT  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            pend_cause_q, pend_cause_d;
  logic                  err_valid_q, err_valid_d;
  logic [1:0]            err_cause_q, err_cause_d;
  logic [PADDR_SIZE-1:0] err_addr_q, err_addr_d;

  logic [SLAVES-1:0]     hit_oh;
  logic [SEL_W-1:0]      hit_idx;
  logic                  any_hit;
  logic                  prot_fault;
  logic                  fwd;
  logic                  setup;
  logic                  sel_rdy;
  logic                  sel_err;
  logic [PDATA_SIZE-1:0] sel_rdata;
  logic                  err_new;
  logic [1:0]            err_new_cause;

  // Address decode, lowest matching index wins
  always_comb begin
    hit_oh  = '0;
    hit_idx = '0;
    any_hit = 1'b0;
    for (int i = 0; i < int'(SLAVES); i++) begin
      if (!any_hit &&
          (((PADDR ^ SLV_ADDR[i*PADDR_SIZE +: PADDR_SIZE]) &
            SLV_MASK[i*PADDR_SIZE +: PADDR_SIZE]) == '0)) begin
        any_hit    = 1'b1;
        hit_idx    = SEL_W'(i);
        hit_oh[i]  = 1'b1;
      end
    end
  end

  assign setup      = PSEL & ~PENABLE;
  assign prot_fault = PROT_EN & ~PPROT[0] & (|(hit_oh & SLV_PRIV));
  assign fwd        = any_hit & ~prot_fault;

  assign sel_rdy   = SLV_PREADY[sel_q];
  assign sel_err   = SLV_PSLVERR[sel_q];
  assign sel_rdata = SLV_PRDATA[sel_q*PDATA_SIZE +: PDATA_SIZE];

  // Next-state and error-capture logic
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    cnt_d         = cnt_q;
    pend_cause_d  = pend_cause_q;
    err_new       = 1'b0;
    err_new_cause = CAUSE_UNMAPPED;

    case (state_q)
      ST_IDLE: begin
        if (setup) begin
          if (fwd) begin
            sel_d   = hit_idx;
            cnt_d   = '0;
            state_d = ST_ACCESS;
          end else begin
            pend_cause_d = prot_fault ? CAUSE_PROT : CAUSE_UNMAPPED;
            state_d      = ST_ERRACC;
          end
        end
      end
      ST_ACCESS: begin
        if (!PSEL) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (sel_rdy) begin
          state_d = ST_IDLE;
        end else begin
          if (WDOG_EN && (cnt_q == CNT_LAST)) state_d = ST_ABORT;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ERRACC: begin
        err_new       = PSEL & PENABLE;
        err_new_cause = pend_cause_q;
        state_d       = ST_IDLE;
      end
      ST_ABORT: begin
        err_new       = 1'b1;
        err_new_cause = CAUSE_TIMEOUT;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    err_valid_d = err_valid_q;
    err_cause_d = err_cause_q;
    err_addr_d  = err_addr_q;
    // A new error beats a simultaneous clear; otherwise the first error sticks
    if (err_new && (!err_valid_q || err_clr_i)) begin
      err_valid_d = 1'b1;
      err_cause_d = err_new_cause;
      err_addr_d  = PADDR;
    end else if (err_clr_i) begin
      err_valid_d = 1'b0;
      err_cause_d = '0;
      err_addr_d  = '0;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      cnt_q        <= '0;
      pend_cause_q <= CAUSE_UNMAPPED;
      err_valid_q  <= 1'b0;
      err_cause_q  <= '0;
      err_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      pend_cause_q <= pend_cause_d;
      err_valid_q  <= err_valid_d;
      err_cause_q  <= err_cause_d;
      err_addr_q   <= err_addr_d;
    end
  end

  // Slave select/enable and master response mux
  always_comb begin
    SLV_PSEL    = '0;
    SLV_PENABLE = '0;
    PREADY      = 1'b1;
    PSLVERR     = 1'b0;
    PRDATA      = '0;

    case (state_q)
      ST_IDLE: begin
        if (setup && fwd && !PRESET) SLV_PSEL = hit_oh;
      end
      ST_ACCESS: begin
        SLV_PSEL[sel_q]    = PSEL;
        SLV_PENABLE[sel_q] = PENABLE;
        PREADY             = sel_rdy;
        PSLVERR            = sel_err;
        PRDATA             = sel_rdata;
      end
      ST_ERRACC: begin
        PSLVERR = PENABLE;
      end
      ST_ABORT: begin
        PSLVERR = 1'b1;
      end
      default: ;
    endcase
  end

  assign SLV_PADDR  = PADDR;
  assign SLV_PWRITE = PWRITE;
  assign SLV_PPROT  = PPROT;
  assign SLV_PSTRB  = PSTRB;
  assign SLV_PWDATA = PWDATA;

  assign err_valid_o = err_valid_q;
  assign err_cause_o = err_cause_q;
  assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_pu_riscv_apb4_slave_mux.sv
// Bench for pu_riscv_apb4_slave_mux: APB master driver, behavioural slaves and a
// scoreboard of expected master responses predicted from an address-range model.
module tb_pu_riscv_apb4_slave_mux;

  localparam int TB_TIMEOUT = 8;
  localparam logic [3:0] TB_PRIV = 4'b0010;

  logic         PCLK, PRESET;
  logic         PSEL, PENABLE, PWRITE;
  logic [2:0]   PPROT;
  logic [15:0]  PADDR;
  logic [3:0]   PSTRB;
  logic [31:0]  PWDATA, PRDATA;
  logic         PREADY, PSLVERR;
  logic [3:0]   slv_psel, slv_pen, slv_rdy, slv_err;
  logic [15:0]  slv_paddr;
  logic         slv_pwrite;
  logic [2:0]   slv_pprot;
  logic [3:0]   slv_pstrb;
  logic [31:0]  slv_pwdata;
  logic [127:0] slv_prdata;
  logic         err_valid;
  logic [1:0]   err_cause;
  logic [15:0]  err_addr;
  logic         err_clr;

  pu_riscv_apb4_slave_mux #(
    .PADDR_SIZE(16), .PDATA_SIZE(32), .SLAVES(4),
    .TIMEOUT_CYCLES(TB_TIMEOUT), .SLV_PRIV(TB_PRIV)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PPROT(PPROT),
    .PADDR(PADDR), .PSTRB(PSTRB), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .SLV_PSEL(slv_psel), .SLV_PENABLE(slv_pen), .SLV_PADDR(slv_paddr),
    .SLV_PWRITE(slv_pwrite), .SLV_PPROT(slv_pprot), .SLV_PSTRB(slv_pstrb),
    .SLV_PWDATA(slv_pwdata), .SLV_PRDATA(slv_prdata),
    .SLV_PREADY(slv_rdy), .SLV_PSLVERR(slv_err),
    .err_valid_o(err_valid), .err_cause_o(err_cause), .err_addr_o(err_addr),
    .err_clr_i(err_clr)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [31:0] rdata;
    logic        slverr;
    int          cycles;
    logic [3:0]  sel;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Behavioural slaves: wait_cfg < 0 means never ready
  int          wait_cfg[4];
  logic [31:0] rdata_cfg[4];
  logic        err_cfg[4];
  int          wcnt[4];
  logic [3:0]  force_rdy;
  int          late_cycle;
  bit          clr_in_access;

  always_comb begin
    slv_rdy    = '0;
    slv_err    = '0;
    slv_prdata = '0;
    for (int i = 0; i < 4; i++) begin
      slv_rdy[i] = force_rdy[i] |
                   (slv_psel[i] & slv_pen[i] & (wait_cfg[i] >= 0) & (wcnt[i] == wait_cfg[i]));
      slv_err[i] = slv_rdy[i] & err_cfg[i];
      slv_prdata[i*32 +: 32] = rdata_cfg[i];
    end
  end

  always @(posedge PCLK) begin
    for (int i = 0; i < 4; i++) begin
      if (slv_psel[i] && slv_pen[i] && !slv_rdy[i]) wcnt[i] <= wcnt[i] + 1;
      else wcnt[i] <= 0;
    end
  end

  function automatic int decode(input logic [15:0] a);
    if (a < 16'h0400) return 0;
    if (a < 16'h0800) return 1;
    if (a < 16'h0C00) return 2;
    if (a >= 16'h8000) return 3;
    return -1;
  endfunction

  function automatic exp_t predict(input logic [15:0] a, input logic [2:0] prot);
    exp_t e;
    int s;
    s = decode(a);
`ifdef APB_PROT_CHECK_EN
    if (s >= 0 && TB_PRIV[s] && !prot[0]) s = -1;
`endif
    if (s < 0) begin
      e.rdata = '0; e.slverr = 1'b1; e.cycles = 2; e.sel = '0;
    end else if (wait_cfg[s] < 0) begin
      e.rdata = '0; e.slverr = 1'b1; e.cycles = TB_TIMEOUT + 2; e.sel = 4'(1 << s);
    end else begin
      e.rdata = rdata_cfg[s]; e.slverr = err_cfg[s]; e.cycles = wait_cfg[s] + 2; e.sel = 4'(1 << s);
    end
    return e;
  endfunction

  // One APB transfer; entered and left at posedge+1, so calls chain back-to-back
  task automatic xfer(input logic [15:0] a, input logic w, input logic [31:0] wd, input logic [2:0] prot);
    exp_t e;
    logic [31:0] rd;
    logic se;
    int cyc;
    bit done;
    exp_q.push_back(predict(a, prot));
    e = exp_q[$];
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = w; PWDATA = wd; PPROT = prot; PSTRB = 4'hF;
    @(negedge PCLK);
    checks++;
    if (slv_psel !== e.sel || slv_pen !== 4'b0) begin
      errors++;
      $display("FAIL setup_sel addr=%h: got psel=%b pen=%b expected psel=%b pen=0000", a, slv_psel, slv_pen, e.sel);
    end
    checks++;
    if (slv_paddr !== a || slv_pwdata !== wd || slv_pwrite !== w || slv_pprot !== prot) begin
      errors++;
      $display("FAIL broadcast addr=%h: got %h/%h/%b/%b expected %h/%h/%b/%b",
               a, slv_paddr, slv_pwdata, slv_pwrite, slv_pprot, a, wd, w, prot);
    end
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    if (clr_in_access) err_clr = 1'b1;
    cyc = 2; done = 0; rd = '0; se = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (cyc == late_cycle) force_rdy = 4'b1000;
      @(negedge PCLK);
      if (PREADY) begin
        done = 1; rd = PRDATA; se = PSLVERR;
      end else begin
        checks++;
        if (slv_psel !== e.sel || slv_pen !== e.sel) begin
          errors++;
          $display("FAIL wait_sel addr=%h cyc=%0d: got psel=%b pen=%b expected %b", a, cyc, slv_psel, slv_pen, e.sel);
        end
      end
      @(posedge PCLK); #1;
      err_clr = 1'b0;
      if (!done) cyc++;
    end
    PSEL = 1'b0; PENABLE = 1'b0; force_rdy = '0;
    e = exp_q.pop_front();
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL pready_timeout addr=%h: got no PREADY in 40 cycles expected PREADY", a);
    end else if (rd !== e.rdata || se !== e.slverr || cyc !== e.cycles) begin
      errors++;
      $display("FAIL response addr=%h: got rdata=%h err=%b cycles=%0d expected rdata=%h err=%b cycles=%0d",
               a, rd, se, cyc, e.rdata, e.slverr, e.cycles);
    end
  endtask

  task automatic check_err(input string name, input logic v, input logic [1:0] c, input logic [15:0] a);
    checks++;
    if (err_valid !== v || err_cause !== c || err_addr !== a) begin
      errors++;
      $display("FAIL %s: got valid=%b cause=%b addr=%h expected valid=%b cause=%b addr=%h",
               name, err_valid, err_cause, err_addr, v, c, a);
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge PCLK); #1;
    err_clr = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (slv_psel !== 4'b0 || slv_pen !== 4'b0 || PREADY !== 1'b1 || PSLVERR !== 1'b0 || PRDATA !== 32'h0) begin
      errors++;
      $display("FAIL %s: got psel=%b pen=%b ready=%b err=%b rdata=%h expected 0000 0000 1 0 00000000",
               name, slv_psel, slv_pen, PREADY, PSLVERR, PRDATA);
    end
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    repeat (2) @(negedge PCLK);
    check_idle_outputs("reset_outputs");
    check_err("reset_err", 1'b0, 2'b00, 16'h0000);
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(posedge PCLK); #1;
  endtask

  task automatic test_read();
    wait_cfg[1] = 2; rdata_cfg[1] = 32'hDEADBEEF; err_cfg[1] = 1'b0;
    xfer(16'h0404, 1'b0, 32'h0, 3'b000);
    check_err("read_no_err", 1'b0, 2'b00, 16'h0000);
  endtask

  task automatic test_unmapped();
    xfer(16'h1000, 1'b1, 32'h11223344, 3'b000);
    check_err("unmapped_capture", 1'b1, 2'b01, 16'h1000);
  endtask

  task automatic test_sticky();
    wait_cfg[3] = -1;
    xfer(16'h9000, 1'b0, 32'h0, 3'b001);
    check_err("sticky_first_wins", 1'b1, 2'b01, 16'h1000);
    pulse_clr();
    check_err("clr_clears", 1'b0, 2'b00, 16'h0000);
  endtask

  task automatic test_timeout();
    late_cycle = TB_TIMEOUT + 2;
    xfer(16'h9000, 1'b0, 32'h0, 3'b001);
    late_cycle = -1;
    check_err("timeout_capture", 1'b1, 2'b11, 16'h9000);
    @(negedge PCLK);
    check_idle_outputs("after_abort_idle");
    @(posedge PCLK); #1;
    pulse_clr();
    xfer(16'h2000, 1'b0, 32'h0, 3'b000);
    check_err("recapture_after_clr", 1'b1, 2'b01, 16'h2000);
  endtask

  task automatic test_clr_collision();
    clr_in_access = 1'b1;
    xfer(16'h3000, 1'b1, 32'hCAFEF00D, 3'b000);
    clr_in_access = 1'b0;
    check_err("clr_and_new_err", 1'b1, 2'b01, 16'h3000);
  endtask

  task automatic test_slave_err();
    pulse_clr();
    wait_cfg[2] = 0; rdata_cfg[2] = 32'h12345678; err_cfg[2] = 1'b1;
    xfer(16'h0810, 1'b0, 32'h0, 3'b000);
    check_err("slave_err_not_captured", 1'b0, 2'b00, 16'h0000);
  endtask

  task automatic test_back_to_back();
    wait_cfg[0] = 0; rdata_cfg[0] = 32'hA5A5_5A5A; err_cfg[0] = 1'b0;
    xfer(16'h0010, 1'b0, 32'h0, 3'b000);
    xfer(16'h0404, 1'b1, 32'h0BADC0DE, 3'b000);
    xfer(16'h4000, 1'b0, 32'h0, 3'b000);
    xfer(16'h0BFC, 1'b0, 32'h0, 3'b000);
    xfer(16'h03FC, 1'b1, 32'h76543210, 3'b000);
    check_err("b2b_capture", 1'b1, 2'b01, 16'h4000);
    pulse_clr();
  endtask

  task automatic test_prot();
    xfer(16'h0400, 1'b0, 32'h0, 3'b000);
`ifdef APB_PROT_CHECK_EN
    check_err("prot_capture", 1'b1, 2'b10, 16'h0400);
    pulse_clr();
`else
    check_err("prot_ignored", 1'b0, 2'b00, 16'h0000);
`endif
    xfer(16'h0400, 1'b0, 32'h0, 3'b001);
    check_err("priv_access_ok", 1'b0, 2'b00, 16'h0000);
  endtask

  task automatic test_reset_mid();
    xfer(16'h1000, 1'b0, 32'h0, 3'b000);
    wait_cfg[1] = -1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 16'h0500; PWRITE = 1'b0; PPROT = 3'b001;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    checks++;
    if (slv_psel !== 4'b0010 || PREADY !== 1'b0) begin
      errors++;
      $display("FAIL mid_access: got psel=%b ready=%b expected psel=0010 ready=0", slv_psel, PREADY);
    end
    #2 PRESET = 1'b1;
    #1;
    check_idle_outputs("async_reset_outputs");
    check_err("async_reset_err", 1'b0, 2'b00, 16'h0000);
    @(posedge PCLK); #1;
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    wait_cfg[1] = 2;
    @(posedge PCLK); #1;
    xfer(16'h0404, 1'b0, 32'h0, 3'b000);
    check_err("post_reset_clean", 1'b0, 2'b00, 16'h0000);
  endtask

  initial begin
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PPROT = 3'b000;
    PADDR = '0; PSTRB = '0; PWDATA = '0; err_clr = 1'b0; PRESET = 1'b1;
    force_rdy = '0; late_cycle = -1; clr_in_access = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_cfg[i] = 0; rdata_cfg[i] = 32'h0; err_cfg[i] = 1'b0; wcnt[i] = 0;
    end
    test_reset();
    test_read();
    test_unmapped();
    test_sticky();
    test_timeout();
    test_clr_collision();
    test_slave_err();
    test_back_to_back();
    test_prot();
    test_reset_mid();
    repeat (2) @(posedge PCLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
